led_bcd_converter: RTL and testbench
====================================

// Module: led_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding the 8-digit
//  seven-segment decoder stage: data_out drives its data_in, seg_sel drives its select.
//  Accepts a binary value over a valid/ready handshake, converts in BIN_W cycles, and holds
//  the packed BCD digits plus a leading-zero blanking mask until the next result.
//  A hex bypass mode passes the raw value through for direct hex display.
// PARAMETERS
//  BIN_W   27  binary input width; must satisfy 2^BIN_W <= 10^(DIGITS+1) and BIN_W <= 4*DIGITS
//  DIGITS   8  displayed digit count; data_out is 4*DIGITS bits, digit i at [4i+3:4i]
// PORTS
//  clk       in   1         clock, all state on rising edge
//  rst_n     in   1         asynchronous active-low reset
//  in_valid  in   1         request: bin_in/hex_mode/lz_en valid
//  in_ready  out  1         converter idle, request accepted when in_valid & in_ready
//  bin_in    in   BIN_W     unsigned value to display
//  hex_mode  in   1         1: bypass, show bin_in as hex digits; 0: decimal conversion
//  lz_en     in   1         1: blank leading zero digits; 0: show all digits
//  data_out  out  4*DIGITS  packed digits to decoder data_in (registered, held)
//  seg_sel   out  DIGITS    digit enable mask to decoder select (registered, held)
//  done      out  1         one-cycle pulse, data_out/seg_sel/ovf just updated
//  ovf       out  1         last decimal result exceeded 10^DIGITS-1 (held)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, data_out=0, seg_sel={{DIGITS-1{0}},1} (shows "0"),
//   done=0, ovf=0, in_ready=1 after release. Reset mid-conversion aborts; no done issued.
//  FSM: IDLE -> SHIFT (accept, hex_mode=0) | DONE (accept, hex_mode=1);
//   SHIFT -> DONE after BIN_W shift cycles; DONE -> IDLE unconditionally.
//  in_ready = (state==IDLE), combinational from state. in_valid outside IDLE is ignored.
//  Accept edge latches bin_in, hex_mode, lz_en into internal shadow regs; later input
//   changes have no effect on the running conversion.
//  SHIFT: scratch = (DIGITS+1)-digit BCD reg + BIN_W binary reg, cleared at accept.
//   Each cycle: every BCD digit >= 5 gets +3, then whole {bcd,bin} shifts left 1 (bin MSB
//   enters BCD LSB). 5-bit bit counter counts BIN_W cycles; exits SHIFT on last count.
//  DONE (one cycle): output regs load at the edge leaving DONE; done=1 for the cycle after.
//   Decimal: data_out = low DIGITS BCD digits; ovf = (digit DIGITS != 0).
//   Hex: data_out = zero-extended bin_in; ovf=0.
//   seg_sel: ovf=1 or lz_en=0 -> all ones. Else bit i=1 for i <= index of highest nonzero
//    digit; digit 0 always enabled (value 0 -> mask ...0001).
//  Latency accept->done: decimal BIN_W+2 cycles (done high in cycle BIN_W+2 after accept
//   edge); hex 2 cycles. Back-to-back: next accept possible the cycle done is high.
//  Outputs hold between results; no combinational path from inputs to data_out/seg_sel/done.
//  Digit values 10..15 never produced in decimal mode; in hex mode any nibble passes.
// TESTING
//  1 bin_in=12345678, lz_en=1, dec -> data_out=32'h12345678, seg_sel=8'hFF, ovf=0, done 29 cyc later.
//  2 bin_in=0, lz_en=1 -> data_out=0, seg_sel=8'h01; same with lz_en=0 -> seg_sel=8'hFF.
//  3 bin_in=305, lz_en=1 -> data_out=32'h00000305, seg_sel=8'h07; 99999999 -> 32'h99999999, 8'hFF.
//  4 bin_in=100000000 (max legal overflow 134217727 too) -> ovf=1, data_out=32'h00000000 /
//    32'h34217727, seg_sel=8'hFF.
//  5 hex_mode=1, bin_in=27'h0ABCDEF, lz_en=1 -> data_out=32'h00ABCDEF, seg_sel=8'h3F, done
//    2 cycles after accept; in_valid held high during SHIFT -> exactly one accept per IDLE.
//  6 rst_n low at SHIFT cycle 10 -> outputs at reset values, no done; in_ready=1 after release,
//    new request of 42 -> data_out=32'h00000042, seg_sel=8'h03.

Source files
------------

// File: rtl/led_bcd_converter.sv
// Sequential binary-to-BCD converter (double dabble) with hex bypass and
// leading-zero blanking, feeding the seven-segment decoder stage.
module led_bcd_converter #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin_in,
    input  logic                hex_mode,
    input  logic                lz_en,
    output logic [4*DIGITS-1:0] data_out,
    output logic [DIGITS-1:0]   seg_sel,
    output logic                done,
    output logic                ovf
);

    localparam int DW = 4 * DIGITS;
    localparam int BW = 4 * (DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [BIN_W-1:0] bin_q;
    logic [BW-1:0]    bcd_q;
    logic [BW-1:0]    bcd_adj;
    logic [4:0]       cnt_q;
    logic             hex_sh;
    logic             lz_sh;
    logic             accept;
    logic             last_bit;
    logic [DW-1:0]    res_data;
    logic [DIGITS-1:0] res_sel;
    logic             res_ovf;
    logic             seen;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & in_ready;
    assign last_bit = (cnt_q == 5'(BIN_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = hex_mode ? DONE : SHIFT;
            SHIFT:   if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i <= DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        res_data = hex_sh ? DW'(bin_q) : bcd_q[DW-1:0];
        res_ovf  = !hex_sh && (bcd_q[BW-1 -: 4] != 4'd0);
        res_sel  = '0;
        seen     = 1'b0;
        // Enable every digit at or below the most significant nonzero one.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen       = seen | (res_data[4*i +: 4] != 4'd0);
            res_sel[i] = seen;
        end
        res_sel[0] = 1'b1;
        if (res_ovf || !lz_sh) begin
            res_sel = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            hex_sh   <= 1'b0;
            lz_sh    <= 1'b0;
            data_out <= '0;
            seg_sel  <= DIGITS'(1);
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                bin_q  <= bin_in;
                bcd_q  <= '0;
                cnt_q  <= '0;
                hex_sh <= hex_mode;
                lz_sh  <= lz_en;
            end else if (state == SHIFT) begin
                bcd_q <= {bcd_adj[BW-2:0], bin_q[BIN_W-1]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q + 5'd1;
            end
            if (state == DONE) begin
                data_out <= res_data;
                seg_sel  <= res_sel;
                ovf      <= res_ovf;
                done     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_bcd_converter.sv
// Directed self-checking bench for led_bcd_converter.
module tb_led_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] bin_in;
    logic        hex_mode;
    logic        lz_en;
    logic [31:0] data_out;
    logic [7:0]  seg_sel;
    logic        done;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [26:0] bin;
        logic        hex;
        logic        lz;
        logic [31:0] exp_data;
        logic [7:0]  exp_sel;
        logic        exp_ovf;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    led_bcd_converter #(.BIN_W(27), .DIGITS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bin_in   (bin_in),
        .hex_mode (hex_mode),
        .lz_en    (lz_en),
        .data_out (data_out),
        .seg_sel  (seg_sel),
        .done     (done),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for done after an accept edge; n counts edges including accept.
    task automatic wait_done(output int n, output bit got);
        n   = 1;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int  n;
        bit  got;
        int  k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        bin_in   = v.bin;
        hex_mode = v.hex;
        lz_en    = v.lz;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs; the running conversion must not see them.
        bin_in   = 27'($urandom);
        hex_mode = ~v.hex;
        lz_en    = ~v.lz;
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        wait_done(n, got);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(n), 32'(v.exp_lat));
        chk({tag, "_data"}, data_out, v.exp_data);
        chk({tag, "_sel"}, 32'(seg_sel), 32'(v.exp_sel));
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.exp_ovf));
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_hold"}, data_out, v.exp_data);
    endtask

    initial begin
        int  n;
        int  hi_cnt;
        bit  got;
        bit  spurious;
        vec_t v;

        vecs[0]  = '{27'd12345678,  1'b0, 1'b1, 32'h12345678, 8'hFF, 1'b0, 29};
        vecs[1]  = '{27'd0,         1'b0, 1'b1, 32'h00000000, 8'h01, 1'b0, 29};
        vecs[2]  = '{27'd0,         1'b0, 1'b0, 32'h00000000, 8'hFF, 1'b0, 29};
        vecs[3]  = '{27'd305,       1'b0, 1'b1, 32'h00000305, 8'h07, 1'b0, 29};
        vecs[4]  = '{27'd99999999,  1'b0, 1'b1, 32'h99999999, 8'hFF, 1'b0, 29};
        vecs[5]  = '{27'd100000000, 1'b0, 1'b1, 32'h00000000, 8'hFF, 1'b1, 29};
        vecs[6]  = '{27'd134217727, 1'b0, 1'b1, 32'h34217727, 8'hFF, 1'b1, 29};
        vecs[7]  = '{27'h0ABCDEF,   1'b1, 1'b1, 32'h00ABCDEF, 8'h3F, 1'b0, 2};
        vecs[8]  = '{27'd42,        1'b0, 1'b1, 32'h00000042, 8'h03, 1'b0, 29};
        vecs[9]  = '{27'd7,         1'b0, 1'b0, 32'h00000007, 8'hFF, 1'b0, 29};
        vecs[10] = '{27'h0000000,   1'b1, 1'b1, 32'h00000000, 8'h01, 1'b0, 2};
        vecs[11] = '{27'd10,        1'b0, 1'b1, 32'h00000010, 8'h03, 1'b0, 29};
        vecs[12] = '{27'h7FFFFFF,   1'b1, 1'b0, 32'h07FFFFFF, 8'hFF, 1'b0, 2};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        hex_mode = 1'b0;
        lz_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_out, 32'd0);
        chk("rst_sel", 32'(seg_sel), 32'h01);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            run(vecs[i], $sformatf("vec%0d", i));
        end

        // in_valid held high: one accept per IDLE visit, back-to-back reaccept.
        @(negedge clk);
        bin_in   = 27'd305;
        hex_mode = 1'b0;
        lz_en    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        hi_cnt = 0;
        n      = 1;
        got    = 1'b0;
        while (n < 100 && !got) begin
            if (in_ready) hi_cnt++;
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        chk("b2b_done_seen", 32'(got), 32'd1);
        chk("b2b_ready_during", 32'(hi_cnt), 32'd0);
        chk("b2b_ready_at_done", 32'(in_ready), 32'd1);
        chk("b2b_data1", data_out, 32'h00000305);
        bin_in = 27'd42;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_reaccept", 32'(in_ready), 32'd0);
        wait_done(n, got);
        chk("b2b_done2_seen", 32'(got), 32'd1);
        chk("b2b_latency2", 32'(n), 32'd29);
        chk("b2b_data2", data_out, 32'h00000042);
        chk("b2b_sel2", 32'(seg_sel), 32'h03);

        // Reset mid-conversion after an overflowing result is displayed.
        run(vecs[6], "pre_rst");
        @(negedge clk);
        bin_in   = 27'd12345678;
        hex_mode = 1'b0;
        lz_en    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_data", data_out, 32'd0);
        chk("abort_sel", 32'(seg_sel), 32'h01);
        chk("abort_ovf", 32'(ovf), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(in_ready), 32'd1);
        spurious = 1'b0;
        repeat (35) begin
            @(posedge clk);
            #1;
            if (done) spurious = 1'b1;
        end
        chk("abort_no_done", 32'(spurious), 32'd0);
        v = vecs[8];
        run(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
